// File: rtl/fifo_stream_out_pkg.sv
// Shared definitions for the fifo read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DATAWIDTH_DEF = 8;
    localparam int unsigned FIFO_RD_LAT   = 1;

    typedef logic [DATAWIDTH_DEF-1:0] data_t;

endpackage

// File: rtl/fifo_stream_out_if.sv
// Handshake bundle: fifo read port on one side, valid/ready stream on the other.
// master = adapter view, slave = fifo + downstream consumer view.
interface fifo_stream_out_if #(
    parameter int unsigned DATAWIDTH = fifo_pkg::DATAWIDTH_DEF
);

    logic [DATAWIDTH-1:0] fifo_rd_data;
    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [DATAWIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        input  fifo_rd_data, fifo_empty, m_ready,
        output fifo_rd_en, m_data, m_valid
    );

    modport slave (
        output fifo_rd_data, fifo_empty, m_ready,
        input  fifo_rd_en, m_data, m_valid
    );

endinterface

// File: rtl/fifo_stream_out_buf.sv
// Circular output buffer: occupancy count, push/pop, head output.
// The head output holds the last popped word while the buffer is empty.
module fifo_stream_buf #(
    parameter  int unsigned DATAWIDTH = fifo_pkg::DATAWIDTH_DEF,
    parameter  int unsigned BUF_DEPTH = 3,
    localparam int unsigned PTR_W     = $clog2(BUF_DEPTH),
    localparam int unsigned OCC_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push_i,
    input  logic [DATAWIDTH-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [OCC_W-1:0]     occ_o,
    output logic [DATAWIDTH-1:0] head_o,
    output logic                 valid_o
);

    logic [DATAWIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [DATAWIDTH-1:0] last_q;
    logic                 pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop     = pop_i && (occ_q != '0);
    assign valid_o = (occ_q != '0);
    assign occ_o   = occ_q;
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        occ_d    = occ_q;
        if (push_i && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_i && pop) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Control registers; last_q keeps the head visible after the final pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (pop) begin
                last_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array, written at wr_ptr on capture.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Occupancy must never exceed the buffer size.
    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (occ_q <= OCC_W'(BUF_DEPTH));
        end
    end

endmodule

// File: rtl/fifo_stream_out.sv
// Read-side adapter: drains a synchronous fifo (1-cycle read latency) into a
// valid/ready stream. fifo_rd_en depends only on registered state and
// fifo_empty, never on m_ready.
// Optional macro STREAM_STALL_CNT_EN adds a saturating stall counter
// (stall_cnt output, stall_clr input).
module fifo_stream_out
    import fifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = fifo_pkg::DATAWIDTH_DEF,
    parameter int unsigned BUF_DEPTH = 3
) (
    input  logic               clk,
    input  logic               resetn,
    fifo_stream_out_if.master  bus
`ifdef STREAM_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt,
    input  logic               stall_clr
`endif
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic             rd_en;
    logic             pop;

    // Issue a read only when the word plus everything already owed fits;
    // resetn gating keeps the strobe low for the whole reset interval.
    always_comb begin
        rd_en = 1'b0;
        if (resetn && !bus.fifo_empty &&
            (({1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}) < (OCC_W + 1)'(BUF_DEPTH))) begin
            rd_en = 1'b1;
        end
        inflight_d = rd_en;
    end

    assign bus.fifo_rd_en = rd_en;
    assign pop            = bus.m_valid && bus.m_ready;

    // Tracks the read whose data arrives next cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_stream_buf #(
        .DATAWIDTH (DATAWIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (inflight_q),
        .push_data_i (bus.fifo_rd_data),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (bus.m_data),
        .valid_o     (bus.m_valid)
    );

`ifdef STREAM_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of stalled cycles; clear takes priority.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (bus.m_valid && !bus.m_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Scoreboard bench for fifo_stream_out with a behavioural upstream fifo.
module tb_fifo_stream_out;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic m_ready = 1'b0;
    logic wr_en = 1'b0;
    logic [7:0] wr_data = '0;

    always #5 clk = ~clk;

    fifo_stream_out_if #(.DATAWIDTH(8)) bus ();

`ifdef STREAM_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic        stall_clr = 1'b0;
`endif

    fifo_stream_out #(.DATAWIDTH(8), .BUF_DEPTH(3)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef STREAM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
`endif
    );

    // Behavioural upstream fifo, unaffected by the adapter's reset.
    logic [7:0] fmem [64];
    logic [5:0] frp = '0;
    logic [5:0] fwp = '0;
    int         fcnt = 0;
    logic [7:0] f_rd_data = '0;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            f_rd_data <= fmem[frp];
            frp <= frp + 1'b1;
        end
        if (wr_en) begin
            fmem[fwp] <= wr_data;
            fwp <= fwp + 1'b1;
        end
        fcnt <= fcnt + int'(wr_en) - int'(bus.fifo_rd_en);
    end

    assign bus.fifo_rd_data = f_rd_data;
    assign bus.fifo_empty   = (fcnt == 0);
    assign bus.m_ready      = m_ready;

    int         n_assert = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    int         beat_cyc [$];
    int         cyc = 0;
    int         rd_total = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: samples at negedge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (resetn) begin
            if (bus.fifo_rd_en) rd_total++;
            chk("rd_en_while_empty", 32'(bus.fifo_rd_en && bus.fifo_empty), 32'd0);
            if (prev_valid && !prev_ready) begin
                chk("valid_held", 32'(bus.m_valid), 32'd1);
                chk("data_held", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.m_valid && bus.m_ready) begin
                beat_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h, required no beat", bus.m_data);
                end else begin
                    chk("beat", 32'(bus.m_data), 32'(exp_q.pop_front()));
                end
            end
            prev_valid = bus.m_valid;
            prev_ready = bus.m_ready;
            prev_data  = bus.m_data;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        exp_q.push_back(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();
    endtask

    initial begin
        logic [7:0] basic [4];
        int rd_base;
        basic[0] = 8'hA1; basic[1] = 8'hB2; basic[2] = 8'hC3; basic[3] = 8'hD4;

        // Reset state
        repeat (3) tick();
        chk("reset_m_valid", 32'(bus.m_valid), 32'd0);
        chk("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("reset_m_data", 32'(bus.m_data), 32'd0);
        resetn = 1'b1;
        tick();

        // Basic drain
        m_ready = 1'b1;
        beat_cyc.delete();
        foreach (basic[i]) push_word(basic[i]);
        wait_drain(50);
        chk("basic_beats", 32'(beat_cyc.size()), 32'd4);
        if (beat_cyc.size() == 4) chk("basic_consecutive", 32'(beat_cyc[3] - beat_cyc[0]), 32'd3);
        chk("idle_m_valid", 32'(bus.m_valid), 32'd0);
        chk("idle_hold_data", 32'(bus.m_data), 32'hD4);

        // Backpressure
        m_ready = 1'b0;
        rd_base = rd_total;
        for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
        repeat (10) tick();
        chk("bp_issues", 32'(rd_total - rd_base), 32'd3);
        chk("bp_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("bp_m_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_m_data", 32'(bus.m_data), 32'h10);
`ifdef STREAM_STALL_CNT_EN
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("stall_clr_first", 32'(stall_cnt), 32'd0);
        repeat (5) tick();
        chk("stall_cnt_5", 32'(stall_cnt), 32'd5);
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        chk("stall_clr", 32'(stall_cnt), 32'd0);
`endif
        m_ready = 1'b1;
        wait_drain(50);

        // Throughput
        beat_cyc.delete();
        for (int i = 0; i < 20; i++) push_word(8'(8'h40 + i));
        wait_drain(60);
        chk("tp_beats", 32'(beat_cyc.size()), 32'd20);
        if (beat_cyc.size() == 20) chk("tp_span", 32'(beat_cyc[19] - beat_cyc[0]), 32'd19);

        // Random ready
        for (int i = 0; i < 64; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            push_word(8'($urandom));
        end
        begin
            int b;
            b = 1000;
            while (exp_q.size() != 0 && b > 0) begin
                m_ready = 1'($urandom_range(0, 1));
                tick();
                b--;
            end
        end
        m_ready = 1'b1;
        wait_drain(20);

        // Reset mid-stream: after 4 pushes from idle, occ=2 and one read in flight
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h70 + i));
        chk("pre_reset_m_valid", 32'(bus.m_valid), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_reset_m_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        chk("mid_reset_m_data", 32'(bus.m_data), 32'd0);
        chk("fifo_left", 32'(fcnt), 32'd1);
        while (exp_q.size() > fcnt) void'(exp_q.pop_front());
        repeat (2) tick();
        resetn = 1'b1;
        m_ready = 1'b1;
        beat_cyc.delete();
        wait_drain(30);
        chk("post_reset_beats", 32'(beat_cyc.size()), 32'd1);
        repeat (5) tick();
        chk("post_reset_idle", 32'(bus.m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
